// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the iterative RV32M divider.
//   - M-extension funct3 encodings for the divide/remainder group
//   - FSM state encoding for div_unit
//   - op decode helper mapping funct3[1:0] to signedness / quotient-vs-remainder
package div_unit_pkg;

    localparam int XLEN_DEF = 32;

    // Full funct3 values of the divide group. The unit only sees funct3[1:0];
    // bit 2 is implied by the decoder having routed the instruction here.
    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    typedef struct packed {
        logic is_signed;  // DIV / REM
        logic is_rem;     // REM / REMU
    } div_op_t;

    function automatic div_op_t decode_op(input logic [1:0] funct3_lo);
        div_op_t    op;
        logic [2:0] f3;
        f3           = {1'b1, funct3_lo};
        op.is_signed = (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
        op.is_rem    = (f3 == FUNCT3_REM) || (f3 == FUNCT3_REMU);
        return op;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational radix-2 restoring division iteration.
//   rem      in   XLEN  partial remainder (always < divisor)
//   quot     in   XLEN  dividend bits still to be consumed / quotient built so far
//   divisor  in   XLEN  divisor magnitude
//   rem_nxt  out  XLEN  partial remainder after this step
//   quot_nxt out  XLEN  quot shifted left with the new quotient bit in bit 0
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_nxt,
    output logic [XLEN-1:0] quot_nxt
);

    // The shifted remainder can reach 2*divisor-1, so one extra bit is needed;
    // the top bit of the difference is then a clean borrow flag.
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted  = {rem, quot[XLEN-1]};
    assign diff     = shifted - {1'b0, divisor};
    assign rem_nxt  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quot_nxt = {quot[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for RV32M DIV/DIVU/REM/REMU in EX.
//   clk          in   1     clock
//   rst          in   1     asynchronous active-high reset
//   start        in   1     EX holds a divide/remainder op (held while stalled)
//   funct3_lo    in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_data     in   XLEN  dividend
//   rs2_data     in   XLEN  divisor
//   kill         in   1     abort in-flight op / block acceptance
//   stall        out  1     freeze PC, IF/ID, ID/EX while a divide is in flight
//   result_valid out  1     one-cycle completion pulse
//   result       out  XLEN  quotient or remainder, held until next completion
// Latency: 1 + XLEN stalled cycles for normal ops, 1 for divide-by-zero and
// signed overflow. The DONE cycle is unstalled and ignores start so the held
// instruction is not relaunched.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      funct3_lo,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            kill,
    output logic            stall,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e state, state_nxt;

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem_q, quot_q, dvsr_q;
    logic [XLEN-1:0] pend_q;    // completed value, exposed during DONE
    logic [XLEN-1:0] result_q;  // last committed value
    logic            is_rem_q, neg_quot_q, neg_rem_q;

    // ------------------------------------------------------------------
    // Operand decode for the acceptance cycle
    // ------------------------------------------------------------------
    div_op_t         op;
    logic            accept;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, overflow, special;
    logic [XLEN-1:0] special_val;

    assign op       = decode_op(funct3_lo);
    assign accept   = (state == ST_IDLE) && start && !kill;
    assign a_neg    = op.is_signed && rs1_data[XLEN-1];
    assign b_neg    = op.is_signed && rs2_data[XLEN-1];
    assign a_mag    = a_neg ? -rs1_data : rs1_data;
    assign b_mag    = b_neg ? -rs2_data : rs2_data;
    assign div_zero = (rs2_data == '0);
    assign overflow = op.is_signed && (rs1_data == INT_MIN) && (rs2_data == '1);
    assign special  = div_zero || overflow;

    always_comb begin
        special_val = '0;
        if (div_zero)
            special_val = op.is_rem ? rs1_data : '1;
        else
            special_val = op.is_rem ? '0 : INT_MIN;
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rem_nxt, quot_nxt;
    logic [XLEN-1:0] quot_fix, rem_fix;

    div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .quot     (quot_q),
        .divisor  (dvsr_q),
        .rem_nxt  (rem_nxt),
        .quot_nxt (quot_nxt)
    );

    assign quot_fix = neg_quot_q ? -quot_nxt : quot_nxt;
    assign rem_fix  = neg_rem_q  ? -rem_nxt  : rem_nxt;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept)
                    state_nxt = special ? ST_DONE : ST_BUSY;
            end
            ST_BUSY: begin
                if (kill)
                    state_nxt = ST_IDLE;
                else if (cnt == '0)
                    state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // rst gates stall so the pipeline is released the moment reset asserts,
    // even while a frozen start is still presented.
    always_comb begin
        stall        = !rst && (accept || (state == ST_BUSY));
        result_valid = (state == ST_DONE) && !kill;
        result       = result_valid ? pend_q : result_q;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dvsr_q     <= '0;
            pend_q     <= '0;
            result_q   <= '0;
            is_rem_q   <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            if (accept) begin
                is_rem_q   <= op.is_rem;
                neg_quot_q <= a_neg ^ b_neg;
                neg_rem_q  <= a_neg;
                dvsr_q     <= b_mag;
                quot_q     <= a_mag;
                rem_q      <= '0;
                cnt        <= CW'(XLEN-1);
                if (special)
                    pend_q <= special_val;
            end else if ((state == ST_BUSY) && !kill) begin
                rem_q  <= rem_nxt;
                quot_q <= quot_nxt;
                cnt    <= cnt - 1'b1;
                if (cnt == '0)
                    pend_q <= is_rem_q ? rem_fix : quot_fix;
            end
            // A kill during DONE leaves the committed result untouched.
            if ((state == ST_DONE) && !kill)
                result_q <= pend_q;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [1:0]  funct3_lo = 2'b00;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        stall, result_valid;
    logic [31:0] result;

    int total = 0;
    int bad = 0;
    int n_pulse = 0;
    bit chk_en = 0;

    div_unit #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .funct3_lo    (funct3_lo),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .kill         (kill),
        .stall        (stall),
        .result_valid (result_valid),
        .result       (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic (RISC-V M semantics) ----------------
    function automatic logic [31:0] ref_div(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return f[1] ? 32'h0 : 32'h8000_0000;
        if (f[0]) return f[1] ? (a % b) : (a / b);
        sa = a;
        sb = b;
        return f[1] ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    function automatic int ref_lat(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        if (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return XLEN + 1;
    endfunction

    // ---------------- behavioural timeline model ----------------
    // m_t: cycles since the accepting cycle (-1 = nothing in flight).
    // The result is visible in cycle m_lat; stall covers cycles 0..m_lat-1.
    int          m_t = -1;
    int          m_lat = 0;
    logic [31:0] m_val = '0;
    logic [31:0] m_res = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t   <= -1;
            m_res <= '0;
        end else if (m_t >= 0) begin
            if (!kill && m_t == m_lat) m_res <= m_val;
            if (kill || m_t == m_lat) m_t <= -1;
            else m_t <= m_t + 1;
        end else if (start && !kill) begin
            m_val <= ref_div(funct3_lo, rs1_data, rs2_data);
            m_lat <= ref_lat(funct3_lo, rs1_data, rs2_data);
            m_t   <= 1;
        end
    end

    always @(negedge clk) begin : cmp
        logic        ev, es;
        logic [31:0] er;
        if (chk_en) begin
            ev = !rst && (m_t >= 0) && (m_t == m_lat) && !kill;
            es = !rst && ((m_t >= 0) ? (m_t < m_lat) : (start && !kill));
            er = ev ? m_val : m_res;
            check("stall", 32'(stall), 32'(es));
            check("result_valid", 32'(result_valid), 32'(ev));
            check("result", result, er);
            if (result_valid) n_pulse++;
        end
    end

    // ---------------- driver ----------------
    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          input bit drop, output logic [31:0] got, output int nstall);
        bit ok;
        @(posedge clk); #1;
        start = 1'b1; funct3_lo = f; rs1_data = a; rs2_data = b;
        nstall = 0; ok = 0; got = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (stall) nstall++;
            if (result_valid) begin ok = 1; got = result; break; end
            if (drop && i == 2) begin
                @(posedge clk); #1;
                start = 1'b0; rs1_data = $urandom; rs2_data = $urandom;
            end
        end
        check("op_completes", 32'(ok), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start = 1'b0; rs1_data = $urandom; rs2_data = $urandom; funct3_lo = 2'($urandom);
        end
    endtask

    typedef struct {
        logic [1:0]  f;
        logic [31:0] a, b, exp;
        int          nst;
    } vec_t;

    vec_t vecs[9] = '{
        '{2'b01, 32'd100,        32'd7,          32'd14,         33},
        '{2'b11, 32'd100,        32'd7,          32'd2,          33},
        '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33},
        '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33},
        '{2'b00, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          33},
        '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1},
        '{2'b11, 32'd5,          32'd0,          32'd5,          1},
        '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1},
        '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1}
    };

    initial begin
        logic [31:0] got;
        int          nst, p0, r;
        logic [1:0]  f;
        logic [31:0] a, b;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_result", result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1;

        // directed vectors, one idle cycle between each
        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, 0, got, nst);
            check($sformatf("dir%0d_result", i), got, vecs[i].exp);
            check($sformatf("dir%0d_stall_cycles", i), 32'(nst), 32'(vecs[i].nst));
            idle(1);
        end

        // back-to-back: second divide presented on the DONE edge, start held
        p0 = n_pulse;
        run_op(2'b01, 32'd100, 32'd7, 0, got, nst);
        check("b2b_first", got, 32'd14);
        run_op(2'b01, 32'd9, 32'd3, 0, got, nst);
        check("b2b_second", got, 32'd3);
        idle(5);
        check("b2b_pulses", 32'(n_pulse - p0), 32'd2);

        // kill in BUSY cycle 10
        p0 = n_pulse;
        @(posedge clk); #1;
        start = 1'b1; funct3_lo = 2'b01; rs1_data = 32'd100; rs2_data = 32'd7;
        repeat (10) @(posedge clk);
        #1 kill = 1'b1;
        @(negedge clk);
        check("kill_cycle_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        kill = 1'b0; start = 1'b0;
        @(negedge clk);
        check("kill_after_stall", 32'(stall), 32'd0);
        check("kill_after_result", result, 32'd3);
        idle(40);
        check("kill_no_pulse", 32'(n_pulse - p0), 32'd0);

        // kill in IDLE blocks acceptance
        @(posedge clk); #1;
        start = 1'b1; kill = 1'b1; funct3_lo = 2'b01; rs1_data = 32'd50; rs2_data = 32'd5;
        @(negedge clk);
        check("kill_idle_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        idle(3);

        // asynchronous reset mid-BUSY
        @(posedge clk); #1;
        start = 1'b1; funct3_lo = 2'b01; rs1_data = 32'd1000; rs2_data = 32'd3;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_valid", 32'(result_valid), 32'd0);
        check("arst_result", result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        idle(2);

        // randomized operations
        for (int n = 0; n < 60; n++) begin
            f = 2'($urandom);
            a = $urandom;
            r = $urandom_range(0, 9);
            case (r)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: b = a;
                4: begin a = $urandom_range(0, 200); b = $urandom; end
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) begin
                // random kill partway through
                @(posedge clk); #1;
                start = 1'b1; funct3_lo = f; rs1_data = a; rs2_data = b;
                repeat ($urandom_range(1, 30)) @(posedge clk);
                #1 kill = 1'b1;
                @(posedge clk); #1;
                kill = 1'b0; start = 1'b0;
            end else begin
                run_op(f, a, b, ($urandom_range(0, 3) == 0), got, nst);
                check("rand_result", got, ref_div(f, a, b));
                check("rand_stall_cycles", 32'(nst), 32'(ref_lat(f, a, b)));
            end
            idle($urandom_range(0, 2));
        end

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
